// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe referee: cell codes, result
// codes, FSM state encoding, board type and the eight winning lines.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  localparam logic [1:0] WHO_NONE      = 2'b00;
  localparam logic [1:0] WHO_PLAYER    = 2'b01;
  localparam logic [1:0] WHO_COMPUTER  = 2'b10;

  localparam logic [3:0] LAST_CELL     = 4'd8;

  typedef enum logic [1:0] {
    PLAYER_TURN   = 2'd0,
    COMPUTER_TURN = 2'd1,
    GAME_DONE     = 2'd2
  } state_e;

  // Cell 0 is top-left, row-major.
  typedef logic [8:0][1:0] board_t;

  // Rows, columns, then the two diagonals.
  localparam logic [3:0] WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/ttt_winner_detect.sv
// Combinational result decode of the registered board.
//   board_i      : nine 2-bit cells, index = cell number
//   who_o        : 00 none, 01 player owns a line, 10 computer owns a line
//   board_full_o : every cell occupied
// If both parties somehow own a line, the player result wins.
module ttt_winner_detect
  import ttt_pkg::*;
(
  input  board_t     board_i,
  output logic [1:0] who_o,
  output logic       board_full_o
);

  logic player_win;
  logic computer_win;

  always_comb begin
    player_win   = 1'b0;
    computer_win = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (board_i[WIN_LINES[l][0]] == CELL_PLAYER &&
          board_i[WIN_LINES[l][1]] == CELL_PLAYER &&
          board_i[WIN_LINES[l][2]] == CELL_PLAYER) begin
        player_win = 1'b1;
      end
      if (board_i[WIN_LINES[l][0]] == CELL_COMPUTER &&
          board_i[WIN_LINES[l][1]] == CELL_COMPUTER &&
          board_i[WIN_LINES[l][2]] == CELL_COMPUTER) begin
        computer_win = 1'b1;
      end
    end
  end

  always_comb begin
    board_full_o = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board_i[i] == CELL_EMPTY) begin
        board_full_o = 1'b0;
      end
    end
  end

  assign who_o = player_win   ? WHO_PLAYER   :
                 computer_win ? WHO_COMPUTER : WHO_NONE;

endmodule

// File: rtl/tic_tac_toe_game.sv
// Tic-tac-toe referee and board store. Validates alternating player and
// computer moves, holds the board and reports the winner.
//   clock, reset          : rising-edge clock, async active-high reset
//   play, pc              : player / computer move request levels
//   player_position       : player target cell 0..8 (9..15 illegal)
//   computer_position     : computer target cell 0..8 (9..15 illegal)
//   pos1..pos9            : cell 0..8 state (00 empty, 01 player, 10 computer)
//   who                   : 00 none/draw/in progress, 01 player, 10 computer
//
// state         | meaning
// PLAYER_TURN   | waiting for a legal player move
// COMPUTER_TURN | waiting for a legal computer move
// GAME_DONE     | win or full board; frozen until reset
module tic_tac_toe_game
  import ttt_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       pc,
  input  logic [3:0] computer_position,
  input  logic [3:0] player_position,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] who
);

  state_e state_q, state_d;
  board_t board_q, board_d;

  logic       board_full;
  logic [1:0] player_cell;
  logic [1:0] computer_cell;
  logic       player_legal;
  logic       computer_legal;

  ttt_winner_detect u_winner (
    .board_i      (board_q),
    .who_o        (who),
    .board_full_o (board_full)
  );

  // Occupancy lookup by loop so out-of-range positions never index the board.
  always_comb begin
    player_cell   = CELL_EMPTY;
    computer_cell = CELL_EMPTY;
    for (int i = 0; i < 9; i++) begin
      if (player_position == i[3:0]) begin
        player_cell = board_q[i];
      end
      if (computer_position == i[3:0]) begin
        computer_cell = board_q[i];
      end
    end
  end

  assign player_legal   = (player_position <= LAST_CELL) && (player_cell == CELL_EMPTY);
  assign computer_legal = (computer_position <= LAST_CELL) && (computer_cell == CELL_EMPTY);

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    unique case (state_q)
      PLAYER_TURN: begin
        // End-of-game check outranks a move arriving in the same cycle.
        if (who != WHO_NONE || board_full) begin
          state_d = GAME_DONE;
        end else if (play && player_legal) begin
          for (int i = 0; i < 9; i++) begin
            if (player_position == i[3:0]) begin
              board_d[i] = CELL_PLAYER;
            end
          end
          state_d = COMPUTER_TURN;
        end
      end
      COMPUTER_TURN: begin
        if (who != WHO_NONE || board_full) begin
          state_d = GAME_DONE;
        end else if (pc && computer_legal) begin
          for (int i = 0; i < 9; i++) begin
            if (computer_position == i[3:0]) begin
              board_d[i] = CELL_COMPUTER;
            end
          end
          state_d = PLAYER_TURN;
        end
      end
      GAME_DONE: begin
        state_d = GAME_DONE;
      end
      default: begin
        state_d = PLAYER_TURN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PLAYER_TURN;
      board_q <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
    end
  end

  assign pos1 = board_q[0];
  assign pos2 = board_q[1];
  assign pos3 = board_q[2];
  assign pos4 = board_q[3];
  assign pos5 = board_q[4];
  assign pos6 = board_q[5];
  assign pos7 = board_q[6];
  assign pos8 = board_q[7];
  assign pos9 = board_q[8];

endmodule

// File: tb/tb_tic_tac_toe_game.sv
module tb_tic_tac_toe_game;

  logic       clock;
  logic       reset;
  logic       play;
  logic       pc;
  logic [3:0] computer_position;
  logic [3:0] player_position;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic [1:0] who;

  int checks;
  int failures;

  logic [1:0] exp_b [9];
  logic [17:0] dut_board;

  tic_tac_toe_game dut (
    .clock             (clock),
    .reset             (reset),
    .play              (play),
    .pc                (pc),
    .computer_position (computer_position),
    .player_position   (player_position),
    .pos1              (pos1),
    .pos2              (pos2),
    .pos3              (pos3),
    .pos4              (pos4),
    .pos5              (pos5),
    .pos6              (pos6),
    .pos7              (pos7),
    .pos8              (pos8),
    .pos9              (pos9),
    .who               (who)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dut_board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  function automatic logic [17:0] exp_vec();
    logic [17:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[2*i +: 2] = exp_b[i];
    return v;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < 9; i++) exp_b[i] = 2'b00;
  endtask

  // Stimulus helpers (no checking): requests applied at a negedge, held n cycles.
  task automatic player_move(input logic [3:0] p, input int n);
    play = 1'b1;
    player_position = p;
    repeat (n) @(negedge clock);
    play = 1'b0;
  endtask

  task automatic computer_move(input logic [3:0] p, input int n);
    pc = 1'b1;
    computer_position = p;
    repeat (n) @(negedge clock);
    pc = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    clear_exp();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) @(negedge clock);
    clear_exp();
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL reset_board got=%h exp=%h", dut_board, exp_vec());
    end
    checks++;
    if (who !== 2'b00) begin
      failures++;
      $display("FAIL reset_who got=%b exp=00", who);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_first_moves();
    player_move(4'd0, 5);
    exp_b[0] = 2'b01;
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL held_play_single_move got=%h exp=%h", dut_board, exp_vec());
    end
    computer_move(4'd4, 5);
    exp_b[4] = 2'b10;
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL computer_move got=%h exp=%h", dut_board, exp_vec());
    end
  endtask

  task automatic test_illegal();
    player_move(4'd4, 5);
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL occupied_cell got=%h exp=%h", dut_board, exp_vec());
    end
    player_move(4'd12, 5);
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL out_of_range got=%h exp=%h", dut_board, exp_vec());
    end
    // Still player's turn: a computer request must not land.
    computer_move(4'd2, 5);
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL pc_on_player_turn got=%h exp=%h", dut_board, exp_vec());
    end
    player_move(4'd5, 5);
    exp_b[5] = 2'b01;
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL legal_after_illegal got=%h exp=%h", dut_board, exp_vec());
    end
  endtask

  task automatic test_player_win();
    apply_reset();
    player_move(4'd0, 5);
    computer_move(4'd4, 5);
    player_move(4'd1, 5);
    computer_move(4'd8, 5);
    // Winning move with a legal pc request held alongside: the pc must be
    // blocked at the very next edge because the game-end check has priority.
    play = 1'b1;
    player_position = 4'd2;
    pc = 1'b1;
    computer_position = 4'd6;
    @(negedge clock);
    checks++;
    if (who !== 2'b01) begin
      failures++;
      $display("FAIL win_who_immediate got=%b exp=01", who);
    end
    repeat (4) @(negedge clock);
    play = 1'b0;
    pc = 1'b0;
    exp_b[0] = 2'b01; exp_b[1] = 2'b01; exp_b[2] = 2'b01;
    exp_b[4] = 2'b10; exp_b[8] = 2'b10;
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL player_win_board got=%h exp=%h", dut_board, exp_vec());
    end
    computer_move(4'd6, 5);
    player_move(4'd3, 5);
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL done_frozen_board got=%h exp=%h", dut_board, exp_vec());
    end
    checks++;
    if (who !== 2'b01) begin
      failures++;
      $display("FAIL player_win_who got=%b exp=01", who);
    end
  endtask

  task automatic test_computer_win();
    apply_reset();
    player_move(4'd0, 5);
    computer_move(4'd4, 5);
    player_move(4'd1, 5);
    computer_move(4'd2, 5);
    player_move(4'd3, 5);
    checks++;
    if (who !== 2'b00) begin
      failures++;
      $display("FAIL before_o6_who got=%b exp=00", who);
    end
    computer_move(4'd6, 5);
    checks++;
    if (who !== 2'b10) begin
      failures++;
      $display("FAIL computer_win_who got=%b exp=10", who);
    end
    player_move(4'd8, 5);
    exp_b[0] = 2'b01; exp_b[1] = 2'b01; exp_b[3] = 2'b01;
    exp_b[4] = 2'b10; exp_b[2] = 2'b10; exp_b[6] = 2'b10;
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL computer_win_board got=%h exp=%h", dut_board, exp_vec());
    end
  endtask

  task automatic test_draw();
    apply_reset();
    player_move(4'd0, 5);
    computer_move(4'd4, 5);
    player_move(4'd2, 5);
    computer_move(4'd1, 5);
    player_move(4'd7, 5);
    computer_move(4'd6, 5);
    player_move(4'd3, 5);
    computer_move(4'd5, 5);
    player_move(4'd8, 5);
    exp_b[0] = 2'b01; exp_b[1] = 2'b10; exp_b[2] = 2'b01;
    exp_b[3] = 2'b01; exp_b[4] = 2'b10; exp_b[5] = 2'b10;
    exp_b[6] = 2'b10; exp_b[7] = 2'b01; exp_b[8] = 2'b01;
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL draw_board got=%h exp=%h", dut_board, exp_vec());
    end
    checks++;
    if (who !== 2'b00) begin
      failures++;
      $display("FAIL draw_who got=%b exp=00", who);
    end
    computer_move(4'd2, 3);
    player_move(4'd1, 3);
    checks++;
    if (dut_board !== exp_vec() || who !== 2'b00) begin
      failures++;
      $display("FAIL draw_frozen got=%h/%b exp=%h/00", dut_board, who, exp_vec());
    end
  endtask

  task automatic test_reset_midgame();
    apply_reset();
    player_move(4'd0, 5);
    computer_move(4'd4, 5);
    player_move(4'd1, 5);
    // Assert reset between edges and look before the next posedge.
    #2;
    reset = 1'b1;
    #1;
    clear_exp();
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL async_reset_clear got=%h exp=%h", dut_board, exp_vec());
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    computer_move(4'd3, 5);
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL pc_after_reset got=%h exp=%h", dut_board, exp_vec());
    end
    player_move(4'd3, 5);
    exp_b[3] = 2'b01;
    checks++;
    if (dut_board !== exp_vec()) begin
      failures++;
      $display("FAIL play_after_reset got=%h exp=%h", dut_board, exp_vec());
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    play = 1'b0;
    pc = 1'b0;
    player_position = 4'd0;
    computer_position = 4'd0;
    clear_exp();
    @(negedge clock);
    test_reset();
    test_first_moves();
    test_illegal();
    test_player_win();
    test_computer_win();
    test_draw();
    test_reset_midgame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
